block_scroll_field: RTL and testbench
=====================================

# block_scroll_field

Parametrised falling-block playfield for the block game. Holds a ROWS×COLS grid of block bits and, every `period+1` enabled cycles, shifts it down one row while inserting a new top row from an internal LFSR. Also scores player key presses against the bottom row and reports hits and misses. It sits between the game timing/control logic and the display driver, which renders `field` directly.

## Interface
Parameters:
- `COLS`, 4: lanes per row; power of two, 2..16.
- `ROWS`, 8: rows in the field, 2..32.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.
- `CNT_W`, 16: width of the hit/miss counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `run`  in  1  scrolling enable; when low, no steps occur but hits are still scored.
- `period`  in  32  cycles between steps minus one; 0 means a step every enabled cycle.
- `gap_mode`  in  1  when 1, a blank row follows every block row.
- `hit_valid`  in  1  one-cycle player press strobe.
- `hit_lane`  in  log2(COLS)  lane pressed.
- `field`  out  ROWS*COLS  grid; row r occupies bits [(ROWS-r)*COLS-1 -: COLS]; row 0 (top) is in the MSBs.
- `step`  out  1  pulses for the cycle after each scroll.
- `hit_ok`  out  1  pulse: press matched a block in the bottom row.
- `hit_bad`  out  1  pulse: press on an empty bottom-row lane.
- `miss`  out  1  pulse: an uncleared block left the bottom row.
- `hit_count`  out  CNT_W  saturating count of `hit_ok`.
- `miss_count`  out  CNT_W  saturating count of `miss`.

## Operation
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. Advances every non-reset cycle. New-row lane is `lfsr[log2(COLS)-1:0]`.
- Period counter `cnt`: while `run`=1, if `cnt >= period` then `cnt<=0` and a step fires; otherwise `cnt<=cnt+1`. While `run`=0, `cnt` holds. The `>=` compare means that lowering `period` mid-count steps on the next enabled cycle. There is no runaway.
- New top row on a step:
  - If `gap_mode`=1 and the previous inserted row was a block row, the new row is all zero.
  - Otherwise the new row is one-hot at the LFSR lane.
  - Internal flag `last_blk` tracks the previous insert. It resets to 0 and is updated on every step regardless of `gap_mode`.
- Step: row r+1 takes row r, and row 0 takes the new row. The bottom row (ROWS-1) is discarded.
- Hit scoring (independent of `run`):
  - Let `clr` = one-hot(`hit_lane`) when `hit_valid`=1, else 0.
  - If `hit_valid` and bottom[`hit_lane`]=1: clear that bit and assert `hit_ok`.
  - If `hit_valid` and the bit is 0: assert `hit_bad`. The field is unchanged.
- Miss: at a step, if `(bottom & ~clr) != 0`, assert `miss`. `miss_count` increments by 1 per step, not per bit.
- Simultaneous hit and step: the hit is judged against the pre-step bottom row. The cleared bit counts as a hit, not a miss, and the shift proceeds in the same cycle.
- Counters saturate at all-ones.

## Timing
- All outputs are registered, with 1-cycle latency from the causing edge.
  - `field` shows the shifted grid on the cycle after the step decision.
  - `step`, `hit_ok`, `hit_bad`, and `miss` are high for exactly one cycle.
- Step spacing is `period+1` cycles of `run`=1. The first step after reset occurs `period+1` enabled cycles after `rst` deasserts.
- Reset (also mid-operation) takes effect at the next clock edge:
  - `field`, `cnt`, `last_blk`, all pulses, and both counters go to 0.
  - The LFSR returns to `SEED`.
  - Any `hit_valid` in the reset cycle is ignored.
- `hit_ok` and `hit_bad` are mutually exclusive. `miss` may coincide with `hit_ok` only if another lane in the bottom row was also set. The generator never produces that, since rows are at most one-hot.
- `hit_lane` is sampled only when `hit_valid`=1.

## Test plan
Bench parameters: COLS=4, ROWS=4.
1. **Reset and first step.** Apply `rst`, then `run`=1, `period`=3 → `field`=0 for 4 cycles. `step` pulses on cycles 4, 8, 12. The top nibble becomes one-hot at `SEED[1:0]`-derived lanes, and the rows shift down each step.
2. **Miss.** `period`=0, `gap_mode`=0, no presses → the first block reaches the bottom after 4 steps. On the 5th step, `miss`=1 and `miss_count`=1; from then on, `miss_count` increments on every step.
3. **Hit and wrong press.**
   - Bottom row = 4'b0100; press `hit_lane`=2 → `hit_ok`=1, bottom row becomes 0, `hit_count`=1, and no `miss` on the next step.
   - Press lane 0 on the same setup → `hit_bad`=1, field unchanged.
4. **Hit coinciding with step.** Bottom = 4'b0001, `hit_valid` with lane 0 in the step cycle → `hit_ok`=1 and `miss`=0. The field shifts normally.
5. **Gap mode and pause.**
   - `gap_mode`=1 → inserted rows alternate one-hot/0000.
   - `run`=0 for 10 cycles → no `step`, `field` frozen, and presses are still scored.
   - `period` lowered from 100 to 2 while `cnt`=50 → step on the next enabled cycle.
6. **Saturation and reset mid-run.**
   - Force `miss_count` to 0xFFFF (CNT_W=16) and cause another miss → `miss_count` holds at 0xFFFF.
   - Assert `rst` mid-run → all outputs 0 on the next edge, and the LFSR sequence restarts identical to scenario 1.

Source files
------------

// File: rtl/block_scroll_field.sv
// Falling-block playfield: scrolls a ROWS x COLS grid downward on a programmable
// period, inserts LFSR-chosen rows at the top, and scores presses against the bottom row.
module block_scroll_field #(
  parameter int unsigned COLS  = 4,
  parameter int unsigned ROWS  = 8,
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            run,
  input  logic [31:0]                     period,
  input  logic                            gap_mode,
  input  logic                            hit_valid,
  input  logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] hit_lane,
  output logic [ROWS*COLS-1:0]            field,
  output logic                            step,
  output logic                            hit_ok,
  output logic                            hit_bad,
  output logic                            miss,
  output logic [CNT_W-1:0]                hit_count,
  output logic [CNT_W-1:0]                miss_count
);

  localparam int unsigned LW   = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned FW   = ROWS * COLS;
  localparam logic [15:0] TAPS = 16'hB400;

  logic [15:0]     lfsr;
  logic [15:0]     lfsr_next;
  logic [31:0]     cnt;
  logic [31:0]     cnt_next;
  logic            last_blk;
  logic            last_blk_next;
  logic [COLS-1:0] bottom;
  logic [COLS-1:0] clr;
  logic [COLS-1:0] new_row;
  logic [FW-1:0]   field_next;
  logic            do_step;
  logic            hit_match;
  logic            miss_next;

  assign bottom = field[COLS-1:0];

  // Next-state: period counter, row insertion, shift and bottom-row clearing.
  always_comb begin
    clr           = '0;
    new_row       = '0;
    cnt_next      = cnt;
    last_blk_next = last_blk;
    field_next    = field;
    miss_next     = 1'b0;

    if (hit_valid) clr = COLS'(1) << hit_lane;
    hit_match = hit_valid & bottom[hit_lane];

    lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? TAPS : 16'h0000);

    do_step = run && (cnt >= period);
    if (run) cnt_next = do_step ? 32'd0 : cnt + 32'd1;

    if (!(gap_mode && last_blk)) new_row = COLS'(1) << lfsr[LW-1:0];

    if (do_step) begin
      // A hit in the step cycle is judged on the pre-step bottom row, so it is not a miss.
      miss_next     = |(bottom & ~clr);
      last_blk_next = |new_row;
      field_next    = {new_row, field[FW-1:COLS]};
    end else begin
      field_next = field & ~FW'(clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr       <= SEED;
      cnt        <= '0;
      last_blk   <= 1'b0;
      field      <= '0;
      step       <= 1'b0;
      hit_ok     <= 1'b0;
      hit_bad    <= 1'b0;
      miss       <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      lfsr     <= lfsr_next;
      cnt      <= cnt_next;
      last_blk <= last_blk_next;
      field    <= field_next;
      step     <= do_step;
      hit_ok   <= hit_match;
      hit_bad  <= hit_valid & ~hit_match;
      miss     <= miss_next;
      // Saturating event counters.
      if (hit_match && (hit_count != '1)) hit_count <= hit_count + CNT_W'(1);
      if (miss_next && (miss_count != '1)) miss_count <= miss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_block_scroll_field.sv
// Randomized and directed bench for block_scroll_field against a grid-level behavioural model.
module tb_block_scroll_field;

  localparam int unsigned COLS = 4;
  localparam int unsigned ROWS = 4;
  localparam int unsigned FW   = ROWS * COLS;
  localparam int unsigned SCW  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          run = 1'b0;
  logic [31:0]   period = 32'd0;
  logic          gap_mode = 1'b0;
  logic          hit_valid = 1'b0;
  logic [1:0]    hit_lane = 2'd0;

  logic [FW-1:0] field;
  logic          step, hit_ok, hit_bad, miss;
  logic [15:0]   hit_count, miss_count;
  logic [FW-1:0] s_field;
  logic          s_step, s_hit_ok, s_hit_bad, s_miss;
  logic [SCW-1:0] s_hit_count, s_miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  block_scroll_field #(.COLS(COLS), .ROWS(ROWS), .SEED(16'hACE1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run), .period(period), .gap_mode(gap_mode),
    .hit_valid(hit_valid), .hit_lane(hit_lane), .field(field), .step(step),
    .hit_ok(hit_ok), .hit_bad(hit_bad), .miss(miss),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter copy sharing the stimulus, used to observe saturation quickly.
  block_scroll_field #(.COLS(COLS), .ROWS(ROWS), .SEED(16'hACE1), .CNT_W(SCW)) dut_sat (
    .clk(clk), .rst(rst), .run(run), .period(period), .gap_mode(gap_mode),
    .hit_valid(hit_valid), .hit_lane(hit_lane), .field(s_field), .step(s_step),
    .hit_ok(s_hit_ok), .hit_bad(s_hit_bad), .miss(s_miss),
    .hit_count(s_hit_count), .miss_count(s_miss_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: rows as integers, counts unbounded.
  int          m_rows[ROWS];
  int unsigned m_lfsr = 32'hACE1;
  int unsigned m_cnt  = 0;
  bit          m_last = 1'b0;
  bit          m_step, m_hok, m_hbad, m_miss;
  int          m_hc = 0;
  int          m_mc = 0;
  int          mb, mclr, mnr;
  bit          mds;

  always @(posedge clk) begin
    if (rst) begin
      foreach (m_rows[r]) m_rows[r] = 0;
      m_lfsr = 32'hACE1; m_cnt = 0; m_last = 1'b0;
      m_step = 1'b0; m_hok = 1'b0; m_hbad = 1'b0; m_miss = 1'b0;
      m_hc = 0; m_mc = 0;
    end else begin
      mb     = m_rows[ROWS-1];
      mclr   = hit_valid ? (1 << hit_lane) : 0;
      m_hok  = hit_valid && (((mb >> hit_lane) & 1) == 1);
      m_hbad = hit_valid && !m_hok;
      mds    = run && (m_cnt >= period);
      if (run) m_cnt = mds ? 0 : m_cnt + 1;
      m_step = mds;
      m_miss = 1'b0;
      if (mds) begin
        m_miss = (mb & ~mclr) != 0;
        mnr    = (gap_mode && m_last) ? 0 : (1 << (m_lfsr % COLS));
        m_last = (mnr != 0);
        for (int r = ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
        m_rows[0] = mnr;
      end else begin
        m_rows[ROWS-1] = mb & ~mclr;
      end
      if (m_hok)  m_hc++;
      if (m_miss) m_mc++;
      m_lfsr = (m_lfsr & 1) ? ((m_lfsr >> 1) ^ 32'hB400) : (m_lfsr >> 1);
    end
  end

  function automatic logic [FW-1:0] exp_field();
    logic [FW-1:0] f;
    f = '0;
    for (int r = 0; r < ROWS; r++) f[(ROWS-r)*COLS-1 -: COLS] = COLS'(m_rows[r]);
    return f;
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic int bottom_lane();
    for (int l = 0; l < COLS; l++) if (((m_rows[ROWS-1] >> l) & 1) == 1) return l;
    return -1;
  endfunction

  logic [FW-1:0] first_run [1:12];

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; hit_valid = 1'b0; gap_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1; hit_valid = 1'b1; hit_lane = 2'd0; period = 32'd3;
    @(negedge clk); @(negedge clk);
    n_checks++;
    if ({field, step, hit_ok, hit_bad, miss} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got field=%h pulses=%b expected 0", field, {step, hit_ok, hit_bad, miss});
    end
    n_checks++;
    if ({hit_count, miss_count, s_hit_count, s_miss_count} !== '0) begin
      n_fail++; $display("FAIL reset_counts: got %h %h expected 0", hit_count, miss_count);
    end
    rst = 1'b0; hit_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      first_run[k] = exp_field();
      n_checks++;
      if (step !== ((k % 4) == 0)) begin
        n_fail++; $display("FAIL first_step k=%0d: got %b expected %b", k, step, (k % 4) == 0);
      end
      n_checks++;
      if (field !== exp_field() || (k < 4 && field !== '0)) begin
        n_fail++; $display("FAIL first_field k=%0d: got %h expected %h", k, field, exp_field());
      end
      if (k == 4) begin
        n_checks++;
        if ($countones(field[FW-1 -: COLS]) != 1) begin
          n_fail++; $display("FAIL first_top_onehot: got %b expected one-hot", field[FW-1 -: COLS]);
        end
      end
    end
  endtask

  task automatic test_miss();
    do_reset();
    period = 32'd0; gap_mode = 1'b0; run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (miss !== (k >= 5) || miss_count !== 16'((k >= 5) ? k - 4 : 0)) begin
        n_fail++; $display("FAIL miss k=%0d: got miss=%b count=%0d expected %b %0d",
                           k, miss, miss_count, k >= 5, (k >= 5) ? k - 4 : 0);
      end
      n_checks++;
      if (field !== exp_field()) begin
        n_fail++; $display("FAIL miss_field k=%0d: got %h expected %h", k, field, exp_field());
      end
    end
  endtask

  task automatic test_hit();
    int lane;
    logic [FW-1:0] saved;
    do_reset();
    period = 32'd0; gap_mode = 1'b0; run = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b0;
    lane = bottom_lane();
    n_checks++;
    if (lane < 0) begin
      n_fail++; $display("FAIL hit_setup: got bottom=%h expected nonzero", m_rows[ROWS-1]);
      lane = 0;
    end
    saved = exp_field();
    hit_valid = 1'b1; hit_lane = 2'((lane + 1) % COLS);
    @(negedge clk);
    hit_valid = 1'b0;
    n_checks++;
    if (hit_bad !== 1'b1 || hit_ok !== 1'b0 || field !== saved) begin
      n_fail++; $display("FAIL wrong_press: got bad=%b ok=%b field=%h expected 1 0 %h", hit_bad, hit_ok, field, saved);
    end
    hit_valid = 1'b1; hit_lane = 2'(lane);
    @(negedge clk);
    hit_valid = 1'b0;
    n_checks++;
    if (hit_ok !== 1'b1 || hit_bad !== 1'b0 || field[COLS-1:0] !== '0 || hit_count !== 16'd1) begin
      n_fail++; $display("FAIL good_press: got ok=%b bad=%b bottom=%b count=%0d expected 1 0 0000 1",
                         hit_ok, hit_bad, field[COLS-1:0], hit_count);
    end
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    n_checks++;
    if (step !== 1'b1 || miss !== 1'b0 || field !== exp_field()) begin
      n_fail++; $display("FAIL step_after_hit: got step=%b miss=%b field=%h expected 1 0 %h", step, miss, field, exp_field());
    end
  endtask

  task automatic test_hit_on_step();
    int lane;
    do_reset();
    period = 32'd0; gap_mode = 1'b0; run = 1'b1;
    repeat (4) @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    lane = bottom_lane();
    if (lane < 0) lane = 0;
    run = 1'b1; hit_valid = 1'b1; hit_lane = 2'(lane);
    @(negedge clk);
    run = 1'b0; hit_valid = 1'b0;
    n_checks++;
    if (hit_ok !== 1'b1 || miss !== 1'b0 || step !== 1'b1 || hit_count !== 16'd1) begin
      n_fail++; $display("FAIL hit_on_step: got ok=%b miss=%b step=%b count=%0d expected 1 0 1 1",
                         hit_ok, miss, step, hit_count);
    end
    n_checks++;
    if (field !== exp_field()) begin
      n_fail++; $display("FAIL hit_on_step_field: got %h expected %h", field, exp_field());
    end
  endtask

  task automatic test_gap_pause();
    logic [FW-1:0] saved;
    do_reset();
    gap_mode = 1'b1; period = 32'd0; run = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      n_checks++;
      if ($countones(field[FW-1 -: COLS]) != ((k % 2) == 1 ? 1 : 0) || field !== exp_field()) begin
        n_fail++; $display("FAIL gap k=%0d: got top=%b field=%h expected %h", k, field[FW-1 -: COLS], field, exp_field());
      end
    end
    run = 1'b0;
    saved = exp_field();
    for (int k = 0; k < 10; k++) begin
      hit_valid = 1'($urandom % 2); hit_lane = 2'($urandom % COLS);
      @(negedge clk);
      n_checks++;
      if (step !== 1'b0 || field[FW-1:COLS] !== saved[FW-1:COLS] || hit_ok !== m_hok || hit_bad !== m_hbad) begin
        n_fail++; $display("FAIL pause k=%0d: got step=%b field=%h ok=%b bad=%b expected 0 %h %b %b",
                           k, step, field, hit_ok, hit_bad, saved, m_hok, m_hbad);
      end
    end
    hit_valid = 1'b0;
    do_reset();
    period = 32'd100; run = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      n_checks++;
      if (step !== 1'b0) begin
        n_fail++; $display("FAIL long_period k=%0d: got step=%b expected 0", k, step);
      end
    end
    period = 32'd2;
    @(negedge clk);
    n_checks++;
    if (step !== 1'b1) begin
      n_fail++; $display("FAIL period_lowered: got step=%b expected 1", step);
    end
  endtask

  task automatic test_saturation_reset();
    do_reset();
    period = 32'd0; gap_mode = 1'b0; run = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      n_checks++;
      if (s_miss_count !== SCW'(sat(m_mc, 3)) || miss_count !== 16'(sat(m_mc, 65535))) begin
        n_fail++; $display("FAIL sat k=%0d: got narrow=%0d wide=%0d expected %0d %0d",
                           k, s_miss_count, miss_count, sat(m_mc, 3), m_mc);
      end
    end
    n_checks++;
    if (s_miss_count !== 2'b11 || miss_count !== 16'd6) begin
      n_fail++; $display("FAIL sat_final: got narrow=%0d wide=%0d expected 3 6", s_miss_count, miss_count);
    end
    rst = 1'b1; hit_valid = 1'b1; hit_lane = 2'd1;
    @(negedge clk);
    n_checks++;
    if ({field, step, hit_ok, hit_bad, miss, hit_count, miss_count, s_miss_count} !== '0) begin
      n_fail++; $display("FAIL midrun_reset: got field=%h pulses=%b counts=%0d/%0d expected all 0",
                         field, {step, hit_ok, hit_bad, miss}, hit_count, miss_count);
    end
    rst = 1'b0; hit_valid = 1'b0; period = 32'd3;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (field !== first_run[k] || field !== exp_field()) begin
        n_fail++; $display("FAIL restart k=%0d: got %h expected %h", k, field, first_run[k]);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rst       = ($urandom % 120) == 0;
      run       = ($urandom % 4) != 0;
      if (($urandom % 16) == 0) period = 32'($urandom % 4);
      if (($urandom % 32) == 0) gap_mode = ~gap_mode;
      hit_valid = ($urandom % 3) == 0;
      hit_lane  = 2'($urandom % COLS);
      @(negedge clk);
      n_checks++;
      if (field !== exp_field() || s_field !== exp_field()) begin
        n_fail++; $display("FAIL rand_field k=%0d: got %h expected %h", k, field, exp_field());
      end
      n_checks++;
      if ({step, hit_ok, hit_bad, miss} !== {m_step, m_hok, m_hbad, m_miss}) begin
        n_fail++; $display("FAIL rand_pulses k=%0d: got %b expected %b", k,
                           {step, hit_ok, hit_bad, miss}, {m_step, m_hok, m_hbad, m_miss});
      end
      n_checks++;
      if (hit_count !== 16'(sat(m_hc, 65535)) || miss_count !== 16'(sat(m_mc, 65535)) ||
          s_hit_count !== SCW'(sat(m_hc, 3)) || s_miss_count !== SCW'(sat(m_mc, 3))) begin
        n_fail++; $display("FAIL rand_counts k=%0d: got %0d/%0d %0d/%0d expected %0d/%0d", k,
                           hit_count, miss_count, s_hit_count, s_miss_count, m_hc, m_mc);
      end
    end
    rst = 1'b0; hit_valid = 1'b0; run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss();
    test_hit();
    test_hit_on_step();
    test_gap_pause();
    test_saturation_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
